// File: rtl/staging_pkg.sv
// ---------------------------------------------------------------------------
// staging_pkg
//   Types and constants shared by the input staging stage and its consumers.
//   stage_word_t  : 32-bit staged word, tag in [31:16], payload in [15:0].
//   TAG_VALID     : tag value marking a present word.
//   TAG_BUBBLE    : tag value marking an empty cycle.
//   slot_state_t  : occupancy of the one-entry result slot.
// ---------------------------------------------------------------------------
package staging_pkg;

    typedef struct packed {
        logic [15:0] tag;
        logic [15:0] payload;
    } stage_word_t;

    localparam logic [15:0] TAG_VALID  = 16'd1;
    localparam logic [15:0] TAG_BUBBLE = 16'd0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } slot_state_t;

endpackage : staging_pkg

// File: rtl/staging_result_slot.sv
// ---------------------------------------------------------------------------
// staging_result_slot
//   One-entry valid/ready holding register. The producer cannot be stalled,
//   so a push into a full slot that is not draining on the same edge is
//   dropped and recorded in a sticky overflow flag.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   push         in   new result offered this cycle
//   push_data    in   DATA_W  result offered with push
//   ready        in   consumer accepts the held result at this edge
//   clear_flags  in   synchronous clear of overflow (a new drop wins)
//   data         out  DATA_W  held result, stable while valid and not drained
//   valid        out  slot holds a result
//   overflow     out  sticky: a pushed result was dropped
// ---------------------------------------------------------------------------
module staging_result_slot
    import staging_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ready,
    input  logic              clear_flags,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overflow
);

    slot_state_t state;
    slot_state_t next_state;
    logic        load;
    logic        drop;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            SLOT_EMPTY: begin
                if (push) begin
                    load       = 1'b1;
                    next_state = SLOT_HELD;
                end
            end
            SLOT_HELD: begin
                if (ready && push) begin
                    // Drain and refill on the same edge: valid never drops.
                    load = 1'b1;
                end else if (ready) begin
                    next_state = SLOT_EMPTY;
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: next_state = SLOT_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SLOT_EMPTY;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                data <= push_data;
            end
            // A drop on the same edge as a clear must leave the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
        end
    end

    assign valid = (state == SLOT_HELD);

endmodule : staging_result_slot

// File: rtl/staging_window_accumulator.sv
// ---------------------------------------------------------------------------
// staging_window_accumulator
//   Consumes staged words, sums the payloads of every WINDOW present words
//   and counts the zero payloads among them. Each completed window is
//   offered to a one-entry output slot; results that find the slot full and
//   not draining are dropped and flagged.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   stageWord    in   32     staged word {tag, payload}, sampled every edge
//   resultSum    out  SUM_W  payload sum of the completed window
//   resultZeros  out  CNT_W  zero-payload count of the completed window
//   resultValid  out  output slot holds a result
//   resultReady  in   consumer accepts the result at this edge
//   clearFlags   in   synchronous clear of overflow and tagError
//   overflow     out  sticky: a completed window was dropped
//   tagError     out  sticky: a tag other than TAG_VALID / bubble was seen
// ---------------------------------------------------------------------------
module staging_window_accumulator #(
    parameter int          WINDOW    = 4,
    parameter logic [15:0] TAG_VALID = staging_pkg::TAG_VALID,
    localparam int         SUM_W     = 16 + $clog2(WINDOW),
    localparam int         CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      stageWord,
    output logic [SUM_W-1:0] resultSum,
    output logic [CNT_W-1:0] resultZeros,
    output logic             resultValid,
    input  logic             resultReady,
    input  logic             clearFlags,
    output logic             overflow,
    output logic             tagError
);

    import staging_pkg::*;

    localparam int SLOT_W = SUM_W + CNT_W;

    stage_word_t      word;
    logic             present;
    logic             tag_bad;
    logic             zero_payload;
    logic             closing;
    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] zero_count;
    logic [SUM_W-1:0] close_sum;
    logic [CNT_W-1:0] close_zeros;
    logic [SLOT_W-1:0] slot_data;

    assign word         = stage_word_t'(stageWord);
    assign present      = (word.tag == TAG_VALID);
    assign tag_bad      = !present && (word.tag != TAG_BUBBLE);
    assign zero_payload = (word.payload == 16'd0);
    assign closing      = present && (word_count == CNT_W'(WINDOW - 1));

    // Running totals including the current word; they double as the next
    // accumulator values and, on the closing word, as the window result.
    assign close_sum   = acc + SUM_W'(word.payload);
    assign close_zeros = zero_count + CNT_W'(zero_payload);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            word_count <= '0;
            zero_count <= '0;
        end else if (present) begin
            if (closing) begin
                // Restart on the same edge so the next word opens a window.
                acc        <= '0;
                word_count <= '0;
                zero_count <= '0;
            end else begin
                acc        <= close_sum;
                word_count <= word_count + CNT_W'(1);
                zero_count <= close_zeros;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tagError <= 1'b0;
        end else if (tag_bad) begin
            tagError <= 1'b1;
        end else if (clearFlags) begin
            tagError <= 1'b0;
        end
    end

    staging_result_slot #(
        .DATA_W (SLOT_W)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .push        (closing),
        .push_data   ({close_sum, close_zeros}),
        .ready       (resultReady),
        .clear_flags (clearFlags),
        .data        (slot_data),
        .valid       (resultValid),
        .overflow    (overflow)
    );

    assign resultSum   = slot_data[SLOT_W-1:CNT_W];
    assign resultZeros = slot_data[CNT_W-1:0];

endmodule : staging_window_accumulator
